tug_of_war_ctrl: RTL and testbench
==================================

Name: tug_of_war_ctrl

Overview:
Game controller that consumes the slowenable strobe from the clock divider. It uses that strobe as its debounce sample tick for the two player buttons and moves a one-hot LED marker toward whichever player presses. It detects a win at either end of the LED bar, keeps per-player saturating scores, and blinks the winning LED until the next start.

Parameters:
NUM_LEDS, 9, LED bar length; odd, >=3; centre index CENTER = (NUM_LEDS-1)/2
DEB_TICKS, 3, consecutive slowenable samples needed to accept a button level change; >=1
BLINK_TICKS, 8, slowenable ticks per half-period of the win blink; >=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
slowenable  in  1  one-clk-wide sample strobe from the divider; synchronous to clk
btn_l  in  1  raw left-player button, asynchronous, bouncing
btn_r  in  1  raw right-player button, asynchronous, bouncing
start  in  1  single-clk synchronous pulse; begins a round
leds  out  NUM_LEDS  marker display; bit NUM_LEDS-1 = left end, bit 0 = right end
win_l  out  1  high while state = WIN_L
win_r  out  1  high while state = WIN_R
score_l  out  4  left wins, saturating at 15
score_r  out  4  right wins, saturating at 15

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pos=CENTER, leds=one-hot CENTER, win_l=win_r=0, scores=0. Synchronisers, debounced levels, debounce counters and blink counter all clear to 0. Reset mid-round discards the round, including scores.
- Sync: each button passes through a 2-flop synchroniser; only the synced level is used.
- Debounce per button (independent, always running in every state):
  - On a clk with slowenable=1: if synced level != debounced level, counter++; else counter=0.
  - When the counter would reach DEB_TICKS, debounced level flips and counter=0.
  - On a clk with slowenable=0: counter and level hold.
- Press event: registered 1-clk pulse on each 0->1 transition of the debounced level. Release generates nothing, so holding a button yields exactly one event.
- FSM states: IDLE, PLAY, WIN_L, WIN_R.
  - IDLE: leds=one-hot CENTER; press events ignored. start -> PLAY with pos=CENTER.
  - PLAY: on the clk after a press event, pos updates:
    - left only: pos+1
    - right only: pos-1
    - both in the same clk: pos unchanged
  - PLAY: the update that makes pos=NUM_LEDS-1 enters WIN_L in the same clk and increments score_l (saturating). pos=0 enters WIN_R likewise for score_r. start in PLAY is ignored.
  - WIN_L/WIN_R: pos frozen; press events ignored; win flag high. The blink counter counts slowenable ticks; every BLINK_TICKS ticks it toggles a blink bit. leds = one-hot pos when blink bit=0, all-zero when blink bit=1. Blink bit is 0 on entry.
  - WIN_L/WIN_R: start -> PLAY, pos=CENTER, win flags clear, blink counter and bit clear.
- Latency: raw press stable from clk k causes leds to change no earlier than 2 (sync) + DEB_TICKS slowenable ticks + 1 (event register) + 1 (pos update) clks.
- Outputs: all registered; no combinational path from any input to any output.
- Arithmetic: pos width = clog2(NUM_LEDS). pos never leaves 0..NUM_LEDS-1, because end positions cause an exit from PLAY. Score increments at 15 hold at 15.

Test Plan:
Defaults; bench drives slowenable high 1 clk in every 4; rst low 5 clks then high.
1. After reset -> leds=9'b000010000, win_l=win_r=0, scores=0. Left press with no start -> leds unchanged.
2. start, then btn_l glitches 1-0-1 within 2 slowenable ticks, then held high 3 ticks -> exactly one move, leds=9'b000100000. Holding 20 more ticks -> no further move.
3. start, then btn_l held only 2 ticks and released -> no move. DEB_TICKS boundary check.
4. start, then btn_l and btn_r rising in the same clk and held -> debounced events coincide, leds stays 9'b000010000.
5. start, then 4 clean right presses -> leds=9'b000000001, win_r=1, score_r=1. After 8 ticks leds=0; after 8 more ticks leds=9'b000000001. start -> leds=9'b000010000, win_r=0.
6. Force score_l to 15 via 15 left wins, then 1 more -> score_l stays 15. rst=0 mid-PLAY at pos=6 -> same clk asynchronously leds=9'b000010000, scores=0, state IDLE.

Source files
------------

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game controller: debounced buttons move a one-hot LED marker,
// win detection at either end, saturating scores and a blinking winner LED.
module tug_of_war_ctrl #(
    parameter int NUM_LEDS    = 9,
    parameter int DEB_TICKS   = 3,
    parameter int BLINK_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slowenable,
    input  logic                btn_l,
    input  logic                btn_r,
    input  logic                start,
    output logic [NUM_LEDS-1:0] leds,
    output logic                win_l,
    output logic                win_r,
    output logic [3:0]          score_l,
    output logic [3:0]          score_r
);

    localparam int PW = $clog2(NUM_LEDS);
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    localparam logic [PW-1:0] CENTER = PW'((NUM_LEDS - 1) / 2);
    localparam logic [PW-1:0] LAST   = PW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] DLAST  = CW'(DEB_TICKS - 1);
    localparam logic [BW-1:0] BLAST  = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        WIN_L,
        WIN_R
    } state_t;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [PW-1:0] p);
        return {{(NUM_LEDS-1){1'b0}}, 1'b1} << p;
    endfunction

    // Index 1 is the left player, index 0 the right player.
    logic [1:0]    s1_q;
    logic [1:0]    s2_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_prev_q;
    logic [1:0]    ev_q;
    logic [CW-1:0] cnt_q [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            ev_q       <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            s1_q       <= {btn_l, btn_r};
            s2_q       <= s1_q;
            deb_prev_q <= deb_q;
            ev_q       <= deb_q & ~deb_prev_q;
            if (slowenable) begin
                for (int i = 0; i < 2; i++) begin
                    if (s2_q[i] == deb_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == DLAST) begin
                        cnt_q[i] <= '0;
                        deb_q[i] <= ~deb_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    state_t        state_q;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_d;
    logic [NUM_LEDS-1:0] leds_q;
    logic          win_l_q;
    logic          win_r_q;
    logic [3:0]    score_l_q;
    logic [3:0]    score_r_q;
    logic [BW-1:0] bcnt_q;
    logic          blink_q;

    // Simultaneous presses cancel out.
    always_comb begin
        pos_d = pos_q;
        if (ev_q[1] && !ev_q[0]) pos_d = pos_q + 1'b1;
        else if (ev_q[0] && !ev_q[1]) pos_d = pos_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pos_q     <= CENTER;
            leds_q    <= onehot(CENTER);
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            bcnt_q    <= '0;
            blink_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    leds_q <= onehot(CENTER);
                    if (start) begin
                        state_q <= PLAY;
                        pos_q   <= CENTER;
                    end
                end
                PLAY: begin
                    pos_q  <= pos_d;
                    leds_q <= onehot(pos_d);
                    if (pos_d == LAST) begin
                        state_q <= WIN_L;
                        win_l_q <= 1'b1;
                        if (score_l_q != 4'hF) score_l_q <= score_l_q + 1'b1;
                    end else if (pos_d == '0) begin
                        state_q <= WIN_R;
                        win_r_q <= 1'b1;
                        if (score_r_q != 4'hF) score_r_q <= score_r_q + 1'b1;
                    end
                end
                WIN_L, WIN_R: begin
                    if (start) begin
                        state_q <= PLAY;
                        pos_q   <= CENTER;
                        leds_q  <= onehot(CENTER);
                        win_l_q <= 1'b0;
                        win_r_q <= 1'b0;
                        bcnt_q  <= '0;
                        blink_q <= 1'b0;
                    end else if (slowenable) begin
                        if (bcnt_q == BLAST) begin
                            bcnt_q  <= '0;
                            blink_q <= ~blink_q;
                            leds_q  <= blink_q ? onehot(pos_q) : '0;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign leds    = leds_q;
    assign win_l   = win_l_q;
    assign win_r   = win_r_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Directed bench for tug_of_war_ctrl: debounce, moves, wins, blink,
// score saturation and asynchronous reset.
module tb_tug_of_war_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       slowenable = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic       start = 1'b0;
    logic [8:0] leds;
    logic       win_l;
    logic       win_r;
    logic [3:0] score_l;
    logic [3:0] score_r;

    int n_chk = 0;
    int n_fail = 0;
    int ph = 0;

    localparam logic [8:0] L_C  = 9'b000010000;
    localparam logic [8:0] L_P5 = 9'b000100000;
    localparam logic [8:0] L_P6 = 9'b001000000;
    localparam logic [8:0] L_P0 = 9'b000000001;

    tug_of_war_ctrl dut (
        .clk(clk), .rst(rst), .slowenable(slowenable),
        .btn_l(btn_l), .btn_r(btn_r), .start(start),
        .leds(leds), .win_l(win_l), .win_r(win_r),
        .score_l(score_l), .score_r(score_r)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            slowenable = (ph == 0);
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (slowenable !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; btn_l = 1'b0; btn_r = 1'b0; start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic l, input logic r);
        btn_l = l; btn_r = r;
        ticks(5);
        btn_l = 1'b0; btn_r = 1'b0;
        ticks(5);
    endtask

    task automatic chk_leds(input string nm, input logic [8:0] exp);
        n_chk++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL %s: leds=%b expected %b", nm, leds, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_leds("reset_leds", L_C);
        n_chk++;
        if ({win_l, win_r} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_win: %b expected 00", {win_l, win_r});
        end
        n_chk++;
        if ({score_l, score_r} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_score: %h expected 00", {score_l, score_r});
        end
        press(1'b1, 1'b0);
        chk_leds("idle_ignore", L_C);
    endtask

    task automatic test_glitch();
        do_reset();
        pulse_start();
        ticks(1);
        btn_l = 1'b1; ticks(1);
        btn_l = 1'b0; ticks(1);
        btn_l = 1'b1; ticks(5);
        chk_leds("glitch_one_move", L_P5);
        ticks(20);
        chk_leds("hold_no_repeat", L_P5);
        btn_l = 1'b0;
        ticks(5);
        chk_leds("release_no_move", L_P5);
    endtask

    task automatic test_deb_boundary();
        do_reset();
        pulse_start();
        ticks(1);
        btn_l = 1'b1;
        ticks(2);
        btn_l = 1'b0;
        ticks(6);
        chk_leds("deb_short", L_C);
    endtask

    task automatic test_both();
        do_reset();
        pulse_start();
        ticks(1);
        btn_l = 1'b1; btn_r = 1'b1;
        ticks(8);
        chk_leds("both_cancel", L_C);
        btn_l = 1'b0; btn_r = 1'b0;
        ticks(5);
        chk_leds("both_release", L_C);
    endtask

    task automatic test_win_blink();
        bit got;
        do_reset();
        pulse_start();
        repeat (3) press(1'b0, 1'b1);
        btn_r = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (win_r === 1'b1) got = 1'b1;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL win_r_timeout: win_r=%b expected 1", win_r);
        end
        chk_leds("win_r_leds", L_P0);
        n_chk++;
        if (score_r !== 4'd1 || win_l !== 1'b0) begin
            n_fail++;
            $display("FAIL win_r_score: score_r=%0d win_l=%b expected 1 0",
                     score_r, win_l);
        end
        btn_r = 1'b0;
        ticks(7);
        chk_leds("blink_7", L_P0);
        ticks(1);
        chk_leds("blink_off", 9'b0);
        ticks(8);
        chk_leds("blink_on", L_P0);
        pulse_start();
        chk_leds("restart_leds", L_C);
        n_chk++;
        if (win_r !== 1'b0 || score_r !== 4'd1) begin
            n_fail++;
            $display("FAIL restart_flags: win_r=%b score_r=%0d expected 0 1",
                     win_r, score_r);
        end
    endtask

    task automatic test_saturate_reset();
        do_reset();
        for (int r = 0; r < 15; r++) begin
            pulse_start();
            repeat (4) press(1'b1, 1'b0);
        end
        n_chk++;
        if (score_l !== 4'd15 || win_l !== 1'b1) begin
            n_fail++;
            $display("FAIL score15: score_l=%0d win_l=%b expected 15 1",
                     score_l, win_l);
        end
        pulse_start();
        repeat (4) press(1'b1, 1'b0);
        n_chk++;
        if (score_l !== 4'd15 || win_l !== 1'b1) begin
            n_fail++;
            $display("FAIL score_sat: score_l=%0d win_l=%b expected 15 1",
                     score_l, win_l);
        end
        pulse_start();
        repeat (2) press(1'b1, 1'b0);
        chk_leds("pos6", L_P6);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_leds("async_rst_leds", L_C);
        n_chk++;
        if ({score_l, score_r, win_l, win_r} !== 10'b0) begin
            n_fail++;
            $display("FAIL async_rst_regs: sl=%0d sr=%0d wl=%b wr=%b expected 0",
                     score_l, score_r, win_l, win_r);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ticks(1);
        press(1'b1, 1'b0);
        chk_leds("post_rst_idle", L_C);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_deb_boundary();
        test_both();
        test_win_blink();
        test_saturate_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
